// File: rtl/uart_tx_frame.sv
// Frame transmitter: HEADER, len payload bytes from a registered byte-read port,
// then an XOR checksum, as gapless 8N1 UART bytes.
module uart_tx_frame #(
  parameter int unsigned CLKS_PER_BIT = 434,
  parameter logic [7:0]  HEADER       = 8'hA5
) (
  input  logic       clk_Tx,
  input  logic       rst,
  input  logic       send,
  input  logic [7:0] len,
  output logic [7:0] rd_addr,
  input  logic [7:0] rd_data,
  output logic       Tx_out,
  output logic       busy,
  output logic       done
);

  typedef enum logic [2:0] {IDLE, START, DATA, STOP, DONE} state_t;

  state_t      state, state_n;
  logic [15:0] clk_cnt, clk_cnt_n;
  logic [2:0]  bit_idx, bit_idx_n;
  logic [8:0]  pay_cnt, pay_cnt_n;
  logic [7:0]  len_q, len_n, shreg, shreg_n, csum, csum_n, addr_n;
  logic        chk_q, chk_n, tx_q, tx_n;
  logic        bit_end, next_pay;

  assign bit_end  = (clk_cnt == 16'(CLKS_PER_BIT - 1));
  // pay_cnt counts payload bytes already loaded, so it is also the next read index
  assign next_pay = !chk_q && (pay_cnt < {1'b0, len_q});

  always_comb begin
    state_n   = state;
    clk_cnt_n = bit_end ? 16'd0 : clk_cnt + 16'd1;
    bit_idx_n = bit_idx;
    pay_cnt_n = pay_cnt;
    len_n     = len_q;
    shreg_n   = shreg;
    csum_n    = csum;
    addr_n    = rd_addr;
    chk_n     = chk_q;
    case (state)
      IDLE, DONE: begin
        clk_cnt_n = 16'd0;
        state_n   = IDLE;
        if (send) begin
          state_n   = START;
          len_n     = len;
          addr_n    = 8'd0;
          pay_cnt_n = 9'd0;
          chk_n     = 1'b0;
          csum_n    = HEADER;
          shreg_n   = HEADER;
        end
      end
      START: begin
        if (bit_end) begin
          state_n   = DATA;
          bit_idx_n = 3'd0;
        end
      end
      DATA: begin
        if (bit_end) begin
          shreg_n   = {1'b0, shreg[7:1]};
          bit_idx_n = bit_idx + 3'd1;
          if (bit_idx == 3'd7) begin
            state_n = STOP;
            // present the address for the whole stop bit so the RAM has a cycle to respond
            if (next_pay) addr_n = pay_cnt[7:0];
          end
        end
      end
      STOP: begin
        if (bit_end) begin
          state_n = START;
          if (next_pay) begin
            shreg_n   = rd_data;
            csum_n    = csum ^ rd_data;
            pay_cnt_n = pay_cnt + 9'd1;
          end else if (!chk_q) begin
            shreg_n = csum;
            chk_n   = 1'b1;
          end else begin
            state_n = DONE;
          end
        end
      end
      default: state_n = IDLE;
    endcase
    case (state_n)
      START:   tx_n = 1'b0;
      DATA:    tx_n = shreg_n[0];
      default: tx_n = 1'b1;
    endcase
  end

  always_ff @(posedge clk_Tx) begin
    if (rst) begin
      state   <= IDLE;
      clk_cnt <= 16'd0;
      bit_idx <= 3'd0;
      pay_cnt <= 9'd0;
      len_q   <= 8'd0;
      shreg   <= 8'd0;
      csum    <= 8'd0;
      rd_addr <= 8'd0;
      chk_q   <= 1'b0;
      tx_q    <= 1'b1;
    end else begin
      state   <= state_n;
      clk_cnt <= clk_cnt_n;
      bit_idx <= bit_idx_n;
      pay_cnt <= pay_cnt_n;
      len_q   <= len_n;
      shreg   <= shreg_n;
      csum    <= csum_n;
      rd_addr <= addr_n;
      chk_q   <= chk_n;
      tx_q    <= tx_n;
    end
  end

  assign Tx_out = tx_q;
  assign busy   = (state == START) || (state == DATA) || (state == STOP);
  assign done   = (state == DONE);

endmodule
